// File: rtl/snic_net_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// snic_net_tx_arbiter_if
// 512-bit AXI-Stream style bundle used on both sides of the network TX arbiter.
//   data  : stream payload, DATA_WIDTH bits
//   keep  : byte enables, KEEP_WIDTH bits
//   last  : end of packet
//   dest  : source tag (only driven on the merged output)
//   valid : producer has a beat
//   ready : consumer takes the beat
// Modports: master = producer side, slave = consumer side (dest not carried).
// ----------------------------------------------------------------------------
interface snic_net_tx_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  dest;
    logic                  valid;
    logic                  ready;

    modport master (
        output data,
        output keep,
        output last,
        output dest,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  keep,
        input  last,
        input  valid,
        output ready
    );
endinterface

// File: rtl/snic_net_tx_arbiter.sv
// ----------------------------------------------------------------------------
// snic_net_tx_arbiter
// Packet-atomic round-robin merge of two TX streams (s0 = TCP engine,
// s1 = endpoint bypass) onto the network TX port. Each output packet carries
// its source index on dest. Packets longer than MAX_FLITS beats are cut: the
// MAX_FLITS-th beat goes out with last forced high and the rest of the input
// packet is swallowed.
// Ports:
//   clk_250mhz, clk_250mhz_rst : clock, synchronous active-high reset
//   arb_enable                 : allow new grants (running packet always ends)
//   s0_axis, s1_axis           : input streams (slave modport)
//   m_axis_net_tx              : registered merged output (master modport)
//   pkt_cnt_0, pkt_cnt_1       : packets emitted per source (wrapping)
//   trunc_cnt                  : packets truncated (wrapping)
//   busy                       : a packet is being passed or dropped
// ----------------------------------------------------------------------------
module snic_net_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned MAX_FLITS  = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk_250mhz,
    input  logic                 clk_250mhz_rst,
    input  logic                 arb_enable,
    snic_net_tx_arbiter_if.slave  s0_axis,
    snic_net_tx_arbiter_if.slave  s1_axis,
    snic_net_tx_arbiter_if.master m_axis_net_tx,
    output logic [CNT_WIDTH-1:0] pkt_cnt_0,
    output logic [CNT_WIDTH-1:0] pkt_cnt_1,
    output logic [CNT_WIDTH-1:0] trunc_cnt,
    output logic                 busy
);

    localparam int unsigned BeatW = $clog2(MAX_FLITS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_FLITS - 1);

    typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0]  m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;
    logic                   m_dest_q, m_dest_d;
    logic                   m_valid_q, m_valid_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_0_q, pkt_cnt_0_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_1_q, pkt_cnt_1_d;
    logic [CNT_WIDTH-1:0]   trunc_cnt_q, trunc_cnt_d;

    logic                   sel_valid;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;
    logic                   sel_last;
    logic                   sel_ready;
    logic                   accept;

    // Granted source view; only meaningful outside StIdle.
    always_comb begin
        sel_valid = grant_q ? s1_axis.valid : s0_axis.valid;
        sel_data  = grant_q ? s1_axis.data  : s0_axis.data;
        sel_keep  = grant_q ? s1_axis.keep  : s0_axis.keep;
        sel_last  = grant_q ? s1_axis.last  : s0_axis.last;
    end

    always_comb begin
        sel_ready = 1'b0;
        case (state_q)
            StPass:  sel_ready = !m_valid_q || m_axis_net_tx.ready;
            StDrop:  sel_ready = 1'b1;
            default: sel_ready = 1'b0;
        endcase
    end

    assign accept        = sel_valid && sel_ready;
    assign s0_axis.ready = sel_ready && !grant_q;
    assign s1_axis.ready = sel_ready && grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_dest_d     = m_dest_q;
        m_valid_d    = m_valid_q;
        pkt_cnt_0_d  = pkt_cnt_0_q;
        pkt_cnt_1_d  = pkt_cnt_1_q;
        trunc_cnt_d  = trunc_cnt_q;

        // Output slot drains independently of the FSM; a load below overrides.
        if (m_valid_q && m_axis_net_tx.ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (arb_enable && (s0_axis.valid || s1_axis.valid)) begin
                    if (s0_axis.valid && s1_axis.valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s1_axis.valid;
                    end
                    last_grant_d = grant_d;
                    beat_cnt_d   = '0;
                    state_d      = StPass;
                end
            end
            StPass: begin
                if (accept) begin
                    m_data_d   = sel_data;
                    m_keep_d   = sel_keep;
                    m_last_d   = sel_last;
                    m_dest_d   = grant_q;
                    m_valid_d  = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_last || (beat_cnt_q == LastBeat)) begin
                        if (grant_q) begin
                            pkt_cnt_1_d = pkt_cnt_1_q + 1'b1;
                        end else begin
                            pkt_cnt_0_d = pkt_cnt_0_q + 1'b1;
                        end
                    end
                    if (sel_last) begin
                        state_d = StIdle;
                    end else if (beat_cnt_q == LastBeat) begin
                        // Runaway packet: close it on the wire, swallow the tail.
                        m_last_d    = 1'b1;
                        trunc_cnt_d = trunc_cnt_q + 1'b1;
                        state_d     = StDrop;
                    end
                end
            end
            StDrop: begin
                if (accept && sel_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_250mhz) begin
        if (clk_250mhz_rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;  // source 0 wins the first tie
            beat_cnt_q   <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_dest_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            pkt_cnt_0_q  <= '0;
            pkt_cnt_1_q  <= '0;
            trunc_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_dest_q     <= m_dest_d;
            m_valid_q    <= m_valid_d;
            pkt_cnt_0_q  <= pkt_cnt_0_d;
            pkt_cnt_1_q  <= pkt_cnt_1_d;
            trunc_cnt_q  <= trunc_cnt_d;
        end
    end

    assign m_axis_net_tx.data  = m_data_q;
    assign m_axis_net_tx.keep  = m_keep_q;
    assign m_axis_net_tx.last  = m_last_q;
    assign m_axis_net_tx.dest  = m_dest_q;
    assign m_axis_net_tx.valid = m_valid_q;
    assign pkt_cnt_0           = pkt_cnt_0_q;
    assign pkt_cnt_1           = pkt_cnt_1_q;
    assign trunc_cnt           = trunc_cnt_q;
    assign busy                = (state_q != StIdle);

endmodule

// File: tb/tb_snic_net_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_snic_net_tx_arbiter
// Directed bench: a cycle table for the first packet and arb_enable gating,
// then hand-written sequences for fairness, truncation, back-pressure,
// mid-packet enable drop and mid-packet reset.
// ----------------------------------------------------------------------------
module tb_snic_net_tx_arbiter;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int MF = 32;
    localparam int CW = 32;

    logic clk_250mhz = 1'b0;
    logic clk_250mhz_rst;
    logic arb_enable;
    logic [CW-1:0] pkt_cnt_0, pkt_cnt_1, trunc_cnt;
    logic busy;

    snic_net_tx_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
    snic_net_tx_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
    snic_net_tx_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    always #2 clk_250mhz = ~clk_250mhz;

    snic_net_tx_arbiter #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .MAX_FLITS (MF),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_250mhz    (clk_250mhz),
        .clk_250mhz_rst(clk_250mhz_rst),
        .arb_enable    (arb_enable),
        .s0_axis       (s0_if),
        .s1_axis       (s1_if),
        .m_axis_net_tx (m_if),
        .pkt_cnt_0     (pkt_cnt_0),
        .pkt_cnt_1     (pkt_cnt_1),
        .trunc_cnt     (trunc_cnt),
        .busy          (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_250mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [63:0] t);
        return {(DW / 64){t}};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input logic [63:0] t);
        return {(KW / 8){t[7:0]}};
    endfunction

    // ---------------- output monitor ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          dest;
        int            cyc;
    } beat_t;

    beat_t obs_q[$];
    beat_t exp_q[$];
    bit    mon_en = 1'b0;
    bit    stall_ready_chk = 1'b0;
    logic  stall_prev = 1'b0;
    logic [DW-1:0] hold_data;
    logic [KW-1:0] hold_keep;
    logic  hold_last, hold_dest;

    always @(negedge clk_250mhz) begin
        if (mon_en && !clk_250mhz_rst) begin
            if (stall_prev) begin
                check("stall valid held", m_if.valid, 1'b1);
                check("stall data held", m_if.data, hold_data);
                check("stall keep held", m_if.keep, hold_keep);
                check("stall last held", m_if.last, hold_last);
                check("stall dest held", m_if.dest, hold_dest);
            end
            if (stall_ready_chk && m_if.valid && !m_if.ready) begin
                check("s0_ready while stalled", s0_if.ready, 1'b0);
            end
            if (m_if.valid && m_if.ready) begin
                obs_q.push_back('{m_if.data, m_if.keep, m_if.last, m_if.dest, cyc});
            end
            stall_prev <= m_if.valid && !m_if.ready;
            hold_data  <= m_if.data;
            hold_keep  <= m_if.keep;
            hold_last  <= m_if.last;
            hold_dest  <= m_if.dest;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    // Expected output of one input packet: cut at MF beats with last forced.
    task automatic exp_pkt(input logic dest, input int len, input logic [63:0] tag);
        int n;
        n = (len > MF) ? MF : len;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{mk_data(tag + 64'(i)), mk_keep(tag + 64'(i)), (i == n - 1), dest, 0});
        end
    endtask

    task automatic check_stream(input string name);
        check({name, " beat count"}, obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size()) begin
            foreach (exp_q[i]) begin
                check($sformatf("%s beat%0d data", name, i), obs_q[i].data, exp_q[i].data);
                check($sformatf("%s beat%0d keep", name, i), obs_q[i].keep, exp_q[i].keep);
                check($sformatf("%s beat%0d last", name, i), obs_q[i].last, exp_q[i].last);
                check($sformatf("%s beat%0d dest", name, i), obs_q[i].dest, exp_q[i].dest);
            end
        end
    endtask

    // ---------------- source drivers ----------------
    task automatic drive_src(input logic src, input logic v, input logic [63:0] t, input logic l);
        if (src) begin
            s1_if.valid = v; s1_if.data = mk_data(t); s1_if.keep = mk_keep(t); s1_if.last = l;
        end else begin
            s0_if.valid = v; s0_if.data = mk_data(t); s0_if.keep = mk_keep(t); s0_if.last = l;
        end
    endtask

    // Called and returns at posedge+1; handshake is sampled on the negedge.
    task automatic send_pkt(input logic src, input int len, input logic [63:0] tag,
                            output bit ok);
        int waited;
        bit hs;
        ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            drive_src(src, 1'b1, tag + 64'(i), (i == len - 1));
            waited = 0;
            hs = 1'b0;
            while (!hs) begin
                @(negedge clk_250mhz);
                hs = src ? (s1_if.valid && s1_if.ready) : (s0_if.valid && s0_if.ready);
                @(posedge clk_250mhz);
                #1;
                if (!hs) begin
                    waited++;
                    if (waited > 200) begin
                        ok = 1'b0;
                        drive_src(src, 1'b0, 64'h0, 1'b0);
                        return;
                    end
                end
            end
        end
        drive_src(src, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        clk_250mhz_rst = 1'b1;
        arb_enable = 1'b1;
        m_if.ready = 1'b1;
        drive_src(1'b0, 1'b0, 64'h0, 1'b0);
        drive_src(1'b1, 1'b0, 64'h0, 1'b0);
        repeat (2) @(posedge clk_250mhz);
        #1;
        clk_250mhz_rst = 1'b0;
        @(negedge clk_250mhz);
        check("reset m_valid", m_if.valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset pkt_cnt_0", pkt_cnt_0, 0);
        check("reset pkt_cnt_1", pkt_cnt_1, 0);
        check("reset trunc_cnt", trunc_cnt, 0);
        @(posedge clk_250mhz);
        #1;
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic s0v, s1v;
        logic [63:0] tag;
        logic last, mrdy, en;
        logic ev;
        logic [63:0] etag;
        logic elast, edest, es0r, es1r, ebusy;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    bit ok_a, ok_b, done4;

    initial begin : main
        s0_if.dest = 1'b0;
        s1_if.dest = 1'b0;

        // s0v s1v tag last mrdy en | ev etag elast edest s0r s1r busy
        vecs[0] = '{1'b1, 1'b0, 64'hA1, 1'b0, 1'b1, 1'b1,
                    1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 64'hA1, 1'b0, 1'b1, 1'b1,
                    1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 64'hA2, 1'b0, 1'b1, 1'b1,
                    1'b1, 64'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 64'hA3, 1'b1, 1'b1, 1'b1,
                    1'b1, 64'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1,
                    1'b1, 64'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1,
                    1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 64'hB1, 1'b1, 1'b1, 1'b0,
                    1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 64'hB1, 1'b1, 1'b1, 1'b0,
                    1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 64'hB1, 1'b1, 1'b1, 1'b0,
                    1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();

        // 1) single 3-beat packet, then arb_enable=0 with both sources valid
        for (int k = 0; k < NV; k++) begin
            drive_src(1'b0, vecs[k].s0v, vecs[k].tag, vecs[k].last);
            drive_src(1'b1, vecs[k].s1v, vecs[k].tag, vecs[k].last);
            m_if.ready = vecs[k].mrdy;
            arb_enable = vecs[k].en;
            @(negedge clk_250mhz);
            check($sformatf("vec%0d m_valid", k), m_if.valid, vecs[k].ev);
            check($sformatf("vec%0d s0_ready", k), s0_if.ready, vecs[k].es0r);
            check($sformatf("vec%0d s1_ready", k), s1_if.ready, vecs[k].es1r);
            check($sformatf("vec%0d busy", k), busy, vecs[k].ebusy);
            if (vecs[k].ev) begin
                check($sformatf("vec%0d data", k), m_if.data, mk_data(vecs[k].etag));
                check($sformatf("vec%0d keep", k), m_if.keep, mk_keep(vecs[k].etag));
                check($sformatf("vec%0d last", k), m_if.last, vecs[k].elast);
                check($sformatf("vec%0d dest", k), m_if.dest, vecs[k].edest);
            end
            @(posedge clk_250mhz);
            #1;
        end
        check("t1 pkt_cnt_0", pkt_cnt_0, 1);
        check("t1 pkt_cnt_1", pkt_cnt_1, 0);

        // 2) both sources back-to-back, 2 packets each of 2 beats
        do_reset();
        mon_en = 1'b1;
        fork
            begin
                send_pkt(1'b0, 2, 64'h10, ok_a);
                if (ok_a) send_pkt(1'b0, 2, 64'h20, ok_a);
            end
            begin
                send_pkt(1'b1, 2, 64'h30, ok_b);
                if (ok_b) send_pkt(1'b1, 2, 64'h40, ok_b);
            end
        join
        repeat (4) @(posedge clk_250mhz);
        #1;
        check("t2 s0 sent", ok_a, 1'b1);
        check("t2 s1 sent", ok_b, 1'b1);
        exp_pkt(1'b0, 2, 64'h10);
        exp_pkt(1'b1, 2, 64'h30);
        exp_pkt(1'b0, 2, 64'h20);
        exp_pkt(1'b1, 2, 64'h40);
        check_stream("t2");
        if (obs_q.size() == 8) begin
            for (int p = 0; p < 4; p++) begin
                check($sformatf("t2 pkt%0d full rate", p), obs_q[2*p+1].cyc, obs_q[2*p].cyc + 1);
            end
            for (int p = 0; p < 3; p++) begin
                check($sformatf("t2 gap%0d one bubble", p), obs_q[2*p+2].cyc,
                      obs_q[2*p+1].cyc + 2);
            end
        end
        check("t2 pkt_cnt_0", pkt_cnt_0, 2);
        check("t2 pkt_cnt_1", pkt_cnt_1, 2);

        // 3) 40-beat runaway on s1, then an intact s0 packet
        do_reset();
        mon_en = 1'b1;
        send_pkt(1'b1, 40, 64'h100, ok_a);
        send_pkt(1'b0, 3, 64'h200, ok_b);
        repeat (3) @(posedge clk_250mhz);
        #1;
        check("t3 s1 all 40 accepted", ok_a, 1'b1);
        check("t3 s0 sent", ok_b, 1'b1);
        exp_pkt(1'b1, 40, 64'h100);
        exp_pkt(1'b0, 3, 64'h200);
        check_stream("t3");
        check("t3 trunc_cnt", trunc_cnt, 1);
        check("t3 pkt_cnt_1", pkt_cnt_1, 1);
        check("t3 pkt_cnt_0", pkt_cnt_0, 1);

        // 4) m_ready toggling under a 4-beat s0 packet
        do_reset();
        mon_en = 1'b1;
        stall_ready_chk = 1'b1;
        done4 = 1'b0;
        fork
            begin
                send_pkt(1'b0, 4, 64'h300, ok_a);
                done4 = 1'b1;
            end
            begin
                for (int k = 0; k < 200 && !done4; k++) begin
                    m_if.ready = ~m_if.ready;
                    @(posedge clk_250mhz);
                    #1;
                end
            end
        join
        m_if.ready = 1'b1;
        repeat (3) @(posedge clk_250mhz);
        #1;
        stall_ready_chk = 1'b0;
        check("t4 s0 sent", ok_a, 1'b1);
        exp_pkt(1'b0, 4, 64'h300);
        check_stream("t4");
        check("t4 pkt_cnt_0", pkt_cnt_0, 1);

        // 5) arb_enable dropped mid-packet: packet ends, no new grant
        do_reset();
        mon_en = 1'b1;
        fork
            send_pkt(1'b0, 4, 64'h400, ok_a);
            begin
                repeat (2) @(posedge clk_250mhz);
                #1;
                arb_enable = 1'b0;
            end
        join
        drive_src(1'b1, 1'b1, 64'h480, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_250mhz);
            check($sformatf("t5 idle%0d busy", k), busy, 1'b0);
            check($sformatf("t5 idle%0d s1_ready", k), s1_if.ready, 1'b0);
            @(posedge clk_250mhz);
            #1;
        end
        check("t5 s0 sent", ok_a, 1'b1);
        exp_pkt(1'b0, 4, 64'h400);
        check_stream("t5");
        check("t5 pkt_cnt_0", pkt_cnt_0, 1);
        check("t5 pkt_cnt_1", pkt_cnt_1, 0);
        drive_src(1'b1, 1'b0, 64'h0, 1'b0);
        arb_enable = 1'b1;

        // 6) reset on beat 2 of a 5-beat packet (counters still hold t5 values)
        mon_en = 1'b0;
        drive_src(1'b0, 1'b1, 64'h500, 1'b0);
        @(posedge clk_250mhz);  // grant
        #1;
        @(posedge clk_250mhz);  // beat 0 accepted
        #1;
        drive_src(1'b0, 1'b1, 64'h501, 1'b0);
        @(posedge clk_250mhz);  // beat 1 accepted
        #1;
        drive_src(1'b0, 1'b1, 64'h502, 1'b0);
        clk_250mhz_rst = 1'b1;
        @(negedge clk_250mhz);
        check("t6 pre-reset m_valid", m_if.valid, 1'b1);
        check("t6 pre-reset data", m_if.data, mk_data(64'h501));
        check("t6 pre-reset pkt_cnt_0", pkt_cnt_0, 1);
        @(posedge clk_250mhz);
        #1;
        clk_250mhz_rst = 1'b0;
        drive_src(1'b0, 1'b0, 64'h0, 1'b0);
        @(negedge clk_250mhz);
        check("t6 m_valid", m_if.valid, 1'b0);
        check("t6 data", m_if.data, '0);
        check("t6 keep", m_if.keep, '0);
        check("t6 last", m_if.last, 1'b0);
        check("t6 dest", m_if.dest, 1'b0);
        check("t6 busy", busy, 1'b0);
        check("t6 s0_ready", s0_if.ready, 1'b0);
        check("t6 pkt_cnt_0", pkt_cnt_0, 0);
        check("t6 pkt_cnt_1", pkt_cnt_1, 0);
        check("t6 trunc_cnt", trunc_cnt, 0);
        @(posedge clk_250mhz);
        #1;
        obs_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        send_pkt(1'b0, 2, 64'h600, ok_a);
        repeat (3) @(posedge clk_250mhz);
        #1;
        check("t6 fresh sent", ok_a, 1'b1);
        exp_pkt(1'b0, 2, 64'h600);
        check_stream("t6 fresh");
        check("t6 fresh pkt_cnt_0", pkt_cnt_0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
